// File: rtl/interconnect_4w4r.sv
// interconnect_4w4r: 4-master x 4-slave crossbar, one round-robin arbiter per slave port
// Ports:
//   iClk, iRst_n                 clock (rising edge), asynchronous active-low reset
//   iMst{m}Req/Cmd/Addr/Sel/WData master m request; Addr[1:0] selects the slave (m = 0..3)
//   oMst{m}Ack/RData             master m completion pulse and read data (0 while ungranted)
//   oSlv{s}Req/Cmd/Addr/Sel/WData slave s request; Addr is the master address shifted right by 2
//   iSlv{s}Ack/RData             slave s completion pulse and read data (ignored while idle)
module interconnect_4w4r #(
  parameter int CMD_W = 1,
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iMst0Req,
  input  logic [CMD_W-1:0] iMst0Cmd,
  input  logic [AW-1:0] iMst0Addr,
  input  logic [SW-1:0] iMst0Sel,
  input  logic [DW-1:0] iMst0WData,
  output logic oMst0Ack,
  output logic [DW-1:0] oMst0RData,
  input  logic iMst1Req,
  input  logic [CMD_W-1:0] iMst1Cmd,
  input  logic [AW-1:0] iMst1Addr,
  input  logic [SW-1:0] iMst1Sel,
  input  logic [DW-1:0] iMst1WData,
  output logic oMst1Ack,
  output logic [DW-1:0] oMst1RData,
  input  logic iMst2Req,
  input  logic [CMD_W-1:0] iMst2Cmd,
  input  logic [AW-1:0] iMst2Addr,
  input  logic [SW-1:0] iMst2Sel,
  input  logic [DW-1:0] iMst2WData,
  output logic oMst2Ack,
  output logic [DW-1:0] oMst2RData,
  input  logic iMst3Req,
  input  logic [CMD_W-1:0] iMst3Cmd,
  input  logic [AW-1:0] iMst3Addr,
  input  logic [SW-1:0] iMst3Sel,
  input  logic [DW-1:0] iMst3WData,
  output logic oMst3Ack,
  output logic [DW-1:0] oMst3RData,
  output logic oSlv0Req,
  output logic [CMD_W-1:0] oSlv0Cmd,
  output logic [AW-1:0] oSlv0Addr,
  output logic [SW-1:0] oSlv0Sel,
  output logic [DW-1:0] oSlv0WData,
  input  logic iSlv0Ack,
  input  logic [DW-1:0] iSlv0RData,
  output logic oSlv1Req,
  output logic [CMD_W-1:0] oSlv1Cmd,
  output logic [AW-1:0] oSlv1Addr,
  output logic [SW-1:0] oSlv1Sel,
  output logic [DW-1:0] oSlv1WData,
  input  logic iSlv1Ack,
  input  logic [DW-1:0] iSlv1RData,
  output logic oSlv2Req,
  output logic [CMD_W-1:0] oSlv2Cmd,
  output logic [AW-1:0] oSlv2Addr,
  output logic [SW-1:0] oSlv2Sel,
  output logic [DW-1:0] oSlv2WData,
  input  logic iSlv2Ack,
  input  logic [DW-1:0] iSlv2RData,
  output logic oSlv3Req,
  output logic [CMD_W-1:0] oSlv3Cmd,
  output logic [AW-1:0] oSlv3Addr,
  output logic [SW-1:0] oSlv3Sel,
  output logic [DW-1:0] oSlv3WData,
  input  logic iSlv3Ack,
  input  logic [DW-1:0] iSlv3RData
);
  typedef enum logic {IDLE, GRANTED} arbState_t;
  logic [3:0] mReq, mAck, sReq, sAck, slvLive;
  logic [CMD_W-1:0] mCmd [4], sCmd [4];
  logic [AW-1:0] mAddr [4], sAddr [4];
  logic [SW-1:0] mSel [4], sSel [4];
  logic [DW-1:0] mWData [4], sWData [4], mRData [4], sRData [4];
  logic [1:0] slvGnt [4];
  assign mReq = {iMst3Req, iMst2Req, iMst1Req, iMst0Req};
  assign mCmd = '{iMst0Cmd, iMst1Cmd, iMst2Cmd, iMst3Cmd};
  assign mAddr = '{iMst0Addr, iMst1Addr, iMst2Addr, iMst3Addr};
  assign mSel = '{iMst0Sel, iMst1Sel, iMst2Sel, iMst3Sel};
  assign mWData = '{iMst0WData, iMst1WData, iMst2WData, iMst3WData};
  assign sAck = {iSlv3Ack, iSlv2Ack, iSlv1Ack, iSlv0Ack};
  assign sRData = '{iSlv0RData, iSlv1RData, iSlv2RData, iSlv3RData};
  for (genvar s = 0; s < 4; s++) begin : gSlv
    arbState_t state, stateNext;
    logic [1:0] gnt, gntNext, ptr, ptrNext;
    logic [3:0] hit;
    always_comb for (int m = 0; m < 4; m++) hit[m] = mReq[m] && mAddr[m][1:0] == 2'(s);
    always_ff @(posedge iClk or negedge iRst_n)
      if (!iRst_n) begin
        state <= IDLE;
        gnt <= '0;
        ptr <= '0;
      end else begin
        state <= stateNext;
        gnt <= gntNext;
        ptr <= ptrNext;
      end
    // ptr holds the master after the last grant; scanning offsets downward lets the
    // requester nearest to ptr win. Leaving GRANTED always costs an idle cycle.
    always_comb begin
      stateNext = state;
      gntNext = gnt;
      ptrNext = ptr;
      if (state == IDLE) begin
        for (int i = 3; i >= 0; i--) if (hit[ptr + 2'(i)]) gntNext = ptr + 2'(i);
        if (|hit) begin
          stateNext = GRANTED;
          ptrNext = gntNext + 2'd1;
        end
      end else if (sAck[s] || !hit[gnt]) stateNext = IDLE;
    end
    // Live only while the granted master still requests and still decodes to this slave.
    assign slvLive[s] = state == GRANTED && hit[gnt];
    assign slvGnt[s] = gnt;
    assign sReq[s] = slvLive[s];
    assign sCmd[s] = state == GRANTED ? mCmd[gnt] : '0;
    assign sAddr[s] = state == GRANTED ? {2'b00, mAddr[gnt][AW-1:2]} : '0;
    assign sSel[s] = state == GRANTED ? mSel[gnt] : '0;
    assign sWData[s] = state == GRANTED ? mWData[gnt] : '0;
  end
  always_comb begin
    mAck = '0;
    for (int m = 0; m < 4; m++) mRData[m] = '0;
    for (int s = 0; s < 4; s++)
      if (slvLive[s]) begin
        mAck[slvGnt[s]] = sAck[s];
        mRData[slvGnt[s]] = sRData[s];
      end
  end
  assign {oMst3Ack, oMst2Ack, oMst1Ack, oMst0Ack} = mAck;
  assign oMst0RData = mRData[0];
  assign oMst1RData = mRData[1];
  assign oMst2RData = mRData[2];
  assign oMst3RData = mRData[3];
  assign {oSlv3Req, oSlv2Req, oSlv1Req, oSlv0Req} = sReq;
  assign oSlv0Cmd = sCmd[0];
  assign oSlv1Cmd = sCmd[1];
  assign oSlv2Cmd = sCmd[2];
  assign oSlv3Cmd = sCmd[3];
  assign oSlv0Addr = sAddr[0];
  assign oSlv1Addr = sAddr[1];
  assign oSlv2Addr = sAddr[2];
  assign oSlv3Addr = sAddr[3];
  assign oSlv0Sel = sSel[0];
  assign oSlv1Sel = sSel[1];
  assign oSlv2Sel = sSel[2];
  assign oSlv3Sel = sSel[3];
  assign oSlv0WData = sWData[0];
  assign oSlv1WData = sWData[1];
  assign oSlv2WData = sWData[2];
  assign oSlv3WData = sWData[3];
endmodule

// File: tb/tb_interconnect_4w4r.sv
// tb_interconnect_4w4r: self-checking bench with slave memory models and a read-data scoreboard
module tb_interconnect_4w4r;
  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;
  logic mReq [4], mCmd [4], mAck [4];
  logic [11:0] mAddr [4];
  logic [3:0] mSel [4];
  logic [31:0] mWData [4], mRData [4];
  logic sReq [4], sCmd [4], sAckD [4], strayAck [4], sAckI [4];
  logic [11:0] sAddr [4];
  logic [3:0] sSel [4];
  logic [31:0] sWData [4], sRDataD [4], strayData [4], sRDataI [4];
  logic [31:0] mem [4][1024];
  logic [31:0] refMem [4][1024];
  logic [31:0] rdQ [4][$];
  int slvLat [4];
  int nChecks = 0;
  int nFails = 0;
  int xferDone = 0;
  always_comb
    for (int s = 0; s < 4; s++) begin
      sAckI[s] = sAckD[s] | strayAck[s];
      sRDataI[s] = sRDataD[s] | strayData[s];
    end
  interconnect_4w4r dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iMst0Req(mReq[0]), .iMst0Cmd(mCmd[0]), .iMst0Addr(mAddr[0]), .iMst0Sel(mSel[0]),
    .iMst0WData(mWData[0]), .oMst0Ack(mAck[0]), .oMst0RData(mRData[0]),
    .iMst1Req(mReq[1]), .iMst1Cmd(mCmd[1]), .iMst1Addr(mAddr[1]), .iMst1Sel(mSel[1]),
    .iMst1WData(mWData[1]), .oMst1Ack(mAck[1]), .oMst1RData(mRData[1]),
    .iMst2Req(mReq[2]), .iMst2Cmd(mCmd[2]), .iMst2Addr(mAddr[2]), .iMst2Sel(mSel[2]),
    .iMst2WData(mWData[2]), .oMst2Ack(mAck[2]), .oMst2RData(mRData[2]),
    .iMst3Req(mReq[3]), .iMst3Cmd(mCmd[3]), .iMst3Addr(mAddr[3]), .iMst3Sel(mSel[3]),
    .iMst3WData(mWData[3]), .oMst3Ack(mAck[3]), .oMst3RData(mRData[3]),
    .oSlv0Req(sReq[0]), .oSlv0Cmd(sCmd[0]), .oSlv0Addr(sAddr[0]), .oSlv0Sel(sSel[0]),
    .oSlv0WData(sWData[0]), .iSlv0Ack(sAckI[0]), .iSlv0RData(sRDataI[0]),
    .oSlv1Req(sReq[1]), .oSlv1Cmd(sCmd[1]), .oSlv1Addr(sAddr[1]), .oSlv1Sel(sSel[1]),
    .oSlv1WData(sWData[1]), .iSlv1Ack(sAckI[1]), .iSlv1RData(sRDataI[1]),
    .oSlv2Req(sReq[2]), .oSlv2Cmd(sCmd[2]), .oSlv2Addr(sAddr[2]), .oSlv2Sel(sSel[2]),
    .oSlv2WData(sWData[2]), .iSlv2Ack(sAckI[2]), .iSlv2RData(sRDataI[2]),
    .oSlv3Req(sReq[3]), .oSlv3Cmd(sCmd[3]), .oSlv3Addr(sAddr[3]), .oSlv3Sel(sSel[3]),
    .oSlv3WData(sWData[3]), .iSlv3Ack(sAckI[3]), .iSlv3RData(sRDataI[3])
  );
  function automatic logic [31:0] byteMask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Slave model: acks a request after slvLat[s] extra cycles (-1 = random 0..2).
  task automatic slaveRun(input int s);
    int cnt, lat;
    logic w;
    logic [9:0] a;
    logic [31:0] d;
    logic [3:0] sl;
    cnt = 0;
    lat = 0;
    forever begin
      @(negedge iClk);
      if (sReq[s]) begin
        if (cnt == 0) lat = slvLat[s] < 0 ? int'($urandom_range(0, 2)) : slvLat[s];
        if (cnt >= lat) begin
          w = sCmd[s];
          a = sAddr[s][9:0];
          d = sWData[s];
          sl = sSel[s];
          @(posedge iClk); #1;
          sAckD[s] = 1'b1;
          if (w) mem[s][a] = (mem[s][a] & ~byteMask(sl)) | (d & byteMask(sl));
          else sRDataD[s] = mem[s][a];
          @(posedge iClk); #1;
          sAckD[s] = 1'b0;
          sRDataD[s] = '0;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  endtask
  task automatic xfer(input int m, input logic wr, input logic [11:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, output int others);
    int s;
    logic [9:0] sa;
    logic [31:0] expD;
    logic got;
    s = int'(addr[1:0]);
    sa = addr[11:2];
    @(posedge iClk); #1;
    mReq[m] = 1'b1;
    mCmd[m] = wr;
    mAddr[m] = addr;
    mSel[m] = sel;
    mWData[m] = wd;
    if (wr) refMem[s][sa] = (refMem[s][sa] & ~byteMask(sel)) | (wd & byteMask(sel));
    else rdQ[m].push_back(refMem[s][sa]);
    others = 0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge iClk);
      for (int o = 0; o < 4; o++) if (o != m && mAck[o]) others++;
      got = mAck[m];
    end
    checkVal($sformatf("m%0d_ack_%03h", m, addr), got, 1);
    if (got) xferDone++;
    if (!wr) begin
      expD = rdQ[m].pop_front();
      checkVal($sformatf("m%0d_rdata_%03h", m, addr), mRData[m], expD);
    end
  endtask
  task automatic idle(input int m, input int n);
    @(posedge iClk); #1;
    mReq[m] = 1'b0;
    mCmd[m] = 1'b0;
    mAddr[m] = '0;
    mSel[m] = '0;
    mWData[m] = '0;
    repeat (n) @(posedge iClk);
  endtask
  task automatic masterDp(input int m);
    int o;
    for (int k = 0; k < 4; k++) xfer(m, 1'b1, 12'(m * 256 + 4 * k + (m + k) % 4), 4'hF, $urandom, o);
    for (int k = 0; k < 4; k++) xfer(m, 1'b0, 12'(m * 256 + 4 * k + (m + k) % 4), 4'hF, '0, o);
    idle(m, 0);
  endtask
  task automatic gap(input int m);
    int d;
    d = int'($urandom_range(0, 4));
    if (d > 0) idle(m, d - 1);
  endtask
  task automatic masterCt(input int m);
    int o;
    logic [11:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 12'(m * 256 + 4 * (i % 4));
      xfer(m, 1'b1, a, 4'($urandom_range(1, 15)), $urandom, o);
      checkVal($sformatf("ct_wait_w%0d", m), o <= 3, 1);
      gap(m);
      xfer(m, 1'b0, a, 4'hF, '0, o);
      checkVal($sformatf("ct_wait_r%0d", m), o <= 3, 1);
      gap(m);
    end
    idle(m, 0);
  endtask
  task automatic rrMaster(input int m);
    int o;
    repeat (2) xfer(m, 1'b0, 12'(m * 256 + 2), 4'hF, '0, o);
    idle(m, 0);
  endtask
  task automatic rrMon();
    logic prev;
    int zeros, n;
    prev = 1'b0;
    zeros = 0;
    n = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      @(negedge iClk);
      if (sReq[2] && !prev) begin
        checkVal($sformatf("rr_order%0d", n), sAddr[2][9:6], n % 4);
        if (n > 0) checkVal($sformatf("rr_gap%0d", n), zeros, 1);
        n++;
      end
      zeros = sReq[2] ? 0 : zeros + 1;
      prev = sReq[2];
    end
    checkVal("rr_grants", n, 5);
  endtask
  task automatic rtMon();
    logic got;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge iClk);
      if (mAck[1]) begin
        got = 1'b1;
        checkVal("rt_rdata", mRData[1], 32'hDEADBEEF);
        checkVal("rt_slvaddr", sAddr[1], 12'h041);
        for (int o = 0; o < 4; o++) if (o != 1) checkVal($sformatf("rt_other%0d", o), mRData[o], 0);
      end
    end
    checkVal("rt_seen", got, 1);
  endtask
  initial fork
    slaveRun(0);
    slaveRun(1);
    slaveRun(2);
    slaveRun(3);
  join
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int o, stale;
    logic got;
    for (int i = 0; i < 4; i++) begin
      mReq[i] = 1'b0; mCmd[i] = 1'b0; mAddr[i] = '0; mSel[i] = '0; mWData[i] = '0;
      sAckD[i] = 1'b0; sRDataD[i] = '0; strayAck[i] = 1'b0; strayData[i] = '0; slvLat[i] = 0;
      for (int j = 0; j < 1024; j++) begin
        mem[i][j] = '0;
        refMem[i][j] = '0;
      end
    end
    mReq[0] = 1'b1;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("rst_sreq%0d", i), sReq[i], 0);
      checkVal($sformatf("rst_saddr%0d", i), sAddr[i], 0);
      checkVal($sformatf("rst_mack%0d", i), mAck[i], 0);
      checkVal($sformatf("rst_mrdata%0d", i), mRData[i], 0);
    end
    mReq[0] = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    fork masterDp(0); masterDp(1); masterDp(2); masterDp(3); join
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 4; k++)
        checkVal($sformatf("dp_mem_m%0d_k%0d", m, k), mem[(m + k) % 4][m * 64 + k], refMem[(m + k) % 4][m * 64 + k]);
    xferDone = 0;
    slvLat[0] = -1;
    fork masterCt(0); masterCt(1); masterCt(2); masterCt(3); join
    checkVal("ct_done", xferDone, 64);
    slvLat[0] = 0;
    fork rrMaster(0); rrMaster(1); rrMaster(2); rrMaster(3); rrMon(); join
    mem[1][10'h041] = 32'hDEADBEEF;
    refMem[1][10'h041] = 32'hDEADBEEF;
    fork xfer(1, 1'b0, 12'h105, 4'hF, '0, o); rtMon(); join
    idle(1, 0);
    strayAck[3] = 1'b1;
    strayData[3] = 32'h12345678;
    @(negedge iClk);
    for (int m = 0; m < 4; m++) begin
      checkVal($sformatf("stray_ack%0d", m), mAck[m], 0);
      checkVal($sformatf("stray_rdata%0d", m), mRData[m], 0);
    end
    @(posedge iClk); #1;
    strayAck[3] = 1'b0;
    strayData[3] = '0;
    slvLat[0] = 50;
    @(posedge iClk); #1;
    mReq[3] = 1'b1; mCmd[3] = 1'b0; mAddr[3] = 12'h300; mSel[3] = 4'hF;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge iClk);
      got = sReq[0];
    end
    checkVal("mr_granted", got, 1);
    checkVal("mr_addr", sAddr[0], 12'h0C0);
    #2 iRst_n = 1'b0;
    #1;
    checkVal("mr_async_req", sReq[0], 0);
    checkVal("mr_async_addr", sAddr[0], 0);
    mReq[1] = 1'b1; mCmd[1] = 1'b0; mAddr[1] = 12'h100; mSel[1] = 4'hF;
    mReq[2] = 1'b1; mCmd[2] = 1'b0; mAddr[2] = 12'h200; mSel[2] = 4'hF;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checkVal("mr_hold_req", sReq[0], 0);
    for (int m = 0; m < 4; m++) checkVal($sformatf("mr_hold_ack%0d", m), mAck[m], 0);
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    got = 1'b0;
    stale = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge iClk);
      if (mAck[3]) stale++;
      got = sReq[0];
    end
    checkVal("mr_regrant", got, 1);
    checkVal("mr_first_grant", sAddr[0], 12'h040);
    checkVal("mr_stale_ack", stale, 0);
    @(posedge iClk); #1;
    for (int m = 1; m < 4; m++) mReq[m] = 1'b0;
    repeat (3) @(posedge iClk);
    slvLat[0] = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
